// File: rtl/cordic_req_scheduler.sv
// Round-robin scheduler sharing one CORDIC sin/cos core between N_REQ requesters.
// Optional one-entry result cache: define CORDIC_REQ_SCHED_CACHE_EN.
module cordic_req_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [16*N_REQ-1:0]   req_angle,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_sine,
    output logic [15:0]           rsp_cosine,
    output logic                  rsp_err,
    output logic                  err_timeout,
    output logic                  core_start,
    output logic [15:0]           core_angle,
    input  logic [15:0]           core_sine,
    input  logic [15:0]           core_cosine,
    input  logic                  core_done,
    output logic [2:0]            state_dbg
);

    // Handshakes: a request is held on req_valid until a one-cycle req_ready
    // pulse accepts it; a response is held on rsp_valid with stable rsp_* until
    // the cycle rsp_ready is seen high, after which rsp_valid drops.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_CLR  = 3'd2,
        WAIT_DONE = 3'd3,
        CAPTURE   = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [WD_W-1:0]  wdog;

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic [15:0]      grant_angle;

    assign state_dbg = state;

    // Two passes: requesters above the pointer first, then wrap to 0..pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_angle = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req_valid[i] && (i > int'(rr_ptr))) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
                grant_angle = req_angle[16*i +: 16];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req_valid[i] && (i <= int'(rr_ptr))) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
                grant_angle = req_angle[16*i +: 16];
            end
        end
    end

`ifdef CORDIC_REQ_SCHED_CACHE_EN
    logic        cache_valid;
    logic [15:0] cache_angle;
    logic [15:0] cache_sine;
    logic [15:0] cache_cosine;
    logic        cache_hit;

    assign cache_hit = cache_valid && (cache_angle == grant_angle);

    // Only successful core results are captured; errors never reach CAPTURE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_valid  <= 1'b0;
            cache_angle  <= '0;
            cache_sine   <= '0;
            cache_cosine <= '0;
        end else if (state == CAPTURE) begin
            cache_valid  <= 1'b1;
            cache_angle  <= core_angle;
            cache_sine   <= core_sine;
            cache_cosine <= core_cosine;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= ID_W'(N_REQ - 1);
            wdog        <= '0;
            req_ready   <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_sine    <= '0;
            rsp_cosine  <= '0;
            rsp_err     <= 1'b0;
            err_timeout <= 1'b0;
            core_start  <= 1'b0;
            core_angle  <= '0;
        end else begin
            req_ready  <= '0;
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        req_ready <= N_REQ'(1) << grant_id;
                        rr_ptr    <= grant_id;
                        rsp_id    <= grant_id;
                        if (grant_angle > 16'd359) begin
                            rsp_err    <= 1'b1;
                            rsp_sine   <= '0;
                            rsp_cosine <= '0;
                            state      <= RESP;
                        end
`ifdef CORDIC_REQ_SCHED_CACHE_EN
                        else if (cache_hit) begin
                            rsp_err    <= 1'b0;
                            rsp_sine   <= cache_sine;
                            rsp_cosine <= cache_cosine;
                            state      <= RESP;
                        end
`endif
                        else begin
                            core_angle <= grant_angle;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    core_start <= 1'b1;
                    wdog       <= '0;
                    state      <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (wdog == WD_LAST) begin
                        rsp_err     <= 1'b1;
                        rsp_sine    <= '0;
                        rsp_cosine  <= '0;
                        err_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (!core_done) state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        state <= CAPTURE;
                    end else if (wdog == WD_LAST) begin
                        rsp_err     <= 1'b1;
                        rsp_sine    <= '0;
                        rsp_cosine  <= '0;
                        err_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                CAPTURE: begin
                    rsp_sine   <= core_sine;
                    rsp_cosine <= core_cosine;
                    rsp_err    <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    // First RESP cycle raises rsp_valid; no grant until the handshake retires it.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
